// File: rtl/punc_ctrl_mc.sv
// Multicycle control FSM for a 16-bit LC-3 style datapath: fetch, decode, execute and memory phases.
// Every instruction takes at least 3 cycles; a memory request is held until mem_ack or until MEM_TIMEOUT wait cycles pass, which faults.
module punc_ctrl_mc #(
    parameter int MEM_TIMEOUT   = 15,
    parameter int STRICT_DECODE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [2:0]  nzp,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_addr_sel,
    output logic        ir_ld,
    output logic        pc_inc,
    output logic        pc_ld,
    output logic        rf_we,
    output logic        cc_ld,
    output logic        mdr_ld,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        MEM_IND,
        HALT,
        FAULT
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RSV  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // Last wait-counter value at which an unacknowledged cycle still counts as waiting.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [3:0]  w_op;
    logic        w_tmo;
    logic        w_unused;

    assign w_op     = ir[15:12];
    assign w_tmo    = (r_wait_cnt == TMO_LAST);
    assign w_unused = ^ir[8:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            // Every memory-state entry is a state change, so this also clears on entry.
            if (w_state_nxt != r_state) begin
                r_wait_cnt <= 8'd0;
            end else if (mem_req && !mem_ack) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 2'd0;
        ir_ld        = 1'b0;
        pc_inc       = 1'b0;
        pc_ld        = 1'b0;
        rf_we        = 1'b0;
        cc_ld        = 1'b0;
        mdr_ld       = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;

        case (r_state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_ld       = 1'b1;
                    pc_inc      = 1'b1;
                    w_state_nxt = DECODE;
                end else if (w_tmo) begin
                    w_state_nxt = FAULT;
                end
            end

            DECODE: w_state_nxt = EXEC;

            EXEC: begin
                w_state_nxt = FETCH;
                case (w_op)
                    OP_ADD, OP_AND, OP_NOT: begin
                        rf_we = 1'b1;
                        cc_ld = 1'b1;
                    end
                    OP_LEA:  rf_we = 1'b1;
                    OP_BR:   pc_ld = |(ir[11:9] & nzp);
                    OP_JMP:  pc_ld = 1'b1;
                    OP_JSR: begin
                        rf_we = 1'b1;
                        pc_ld = 1'b1;
                    end
                    OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: w_state_nxt = MEM;
                    OP_TRAP: w_state_nxt = HALT;
                    OP_RTI, OP_RSV: begin
                        if (STRICT_DECODE != 0) begin
                            w_state_nxt = FAULT;
                        end
                    end
                    default: w_state_nxt = FETCH;
                endcase
            end

            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = (w_op == OP_LDR || w_op == OP_STR) ? 2'd2 : 2'd1;
                mem_we       = (w_op == OP_ST || w_op == OP_STR);
                if (mem_ack) begin
                    w_state_nxt = FETCH;
                    if (w_op == OP_LD || w_op == OP_LDR) begin
                        rf_we = 1'b1;
                        cc_ld = 1'b1;
                    end else if (w_op == OP_LDI || w_op == OP_STI) begin
                        mdr_ld      = 1'b1;
                        w_state_nxt = MEM_IND;
                    end
                end else if (w_tmo) begin
                    w_state_nxt = FAULT;
                end
            end

            MEM_IND: begin
                mem_req      = 1'b1;
                mem_addr_sel = 2'd3;
                mem_we       = (w_op == OP_STI);
                if (mem_ack) begin
                    w_state_nxt = FETCH;
                    if (w_op == OP_LDI) begin
                        rf_we = 1'b1;
                        cc_ld = 1'b1;
                    end
                end else if (w_tmo) begin
                    w_state_nxt = FAULT;
                end
            end

            HALT:  halted = 1'b1;

            FAULT: fault = 1'b1;

            default: w_state_nxt = FAULT;
        endcase
    end

endmodule

// File: tb/tb_punc_ctrl_mc.sv
// Bench for punc_ctrl_mc: an instruction-level model expands each instruction and its memory
// latencies into the expected per-cycle output trace, which is compared against the DUT.
module tb_punc_ctrl_mc;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        mem_ack;
    logic        mem_req, mem_we, ir_ld, pc_inc, pc_ld, rf_we, cc_ld, mdr_ld, halted, fault;
    logic [1:0]  mem_addr_sel;
    logic [11:0] obs_w;

    always #5 clk = ~clk;

    punc_ctrl_mc #(.MEM_TIMEOUT(T), .STRICT_DECODE(1)) dut (
        .clk(clk), .rst(rst), .ir(ir), .nzp(nzp), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .rf_we(rf_we),
        .cc_ld(cc_ld), .mdr_ld(mdr_ld), .halted(halted), .fault(fault)
    );

    assign obs_w = {mem_req, mem_we, mem_addr_sel, ir_ld, pc_inc, pc_ld,
                    rf_we, cc_ld, mdr_ld, halted, fault};

    localparam logic [11:0] B_IRLD  = 12'h080;
    localparam logic [11:0] B_PCINC = 12'h040;
    localparam logic [11:0] B_PCLD  = 12'h020;
    localparam logic [11:0] B_RFWE  = 12'h010;
    localparam logic [11:0] B_CCLD  = 12'h008;
    localparam logic [11:0] B_MDR   = 12'h004;
    localparam logic [11:0] B_HALT  = 12'h002;
    localparam logic [11:0] B_FAULT = 12'h001;

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    bit          ack_q[$];

    function automatic logic [11:0] req_vec(input logic we, input logic [1:0] sel);
        return {1'b1, we, sel, 8'h00};
    endfunction

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [11:0] e, input bit a);
        exp_q.push_back(e);
        ack_q.push_back(a);
    endtask

    // One memory request answered after d idle cycles; d >= T means the answer never comes.
    task automatic mem_phase(input logic [1:0] sel, input logic we, input int d,
                             input logic [11:0] extra, output bit to);
        int n = (d >= T) ? T : d;
        for (int i = 0; i < n; i++) push(req_vec(we, sel), 1'b0);
        if (d >= T) begin
            repeat (3) push(B_FAULT, rnd());
            to = 1'b1;
        end else begin
            push(req_vec(we, sel) | extra, 1'b1);
            to = 1'b0;
        end
    endtask

    task automatic model_instr(input logic [15:0] iv, input logic [2:0] nv,
                               input int d0, input int d1, input int d2, output bit term);
        logic [3:0] op;
        logic [1:0] sel;
        logic       we, ind, ld;
        bit         to;
        exp_q.delete();
        ack_q.delete();
        term = 1'b0;
        op   = iv[15:12];
        mem_phase(2'd0, 1'b0, d0, B_IRLD | B_PCINC, to);
        if (to) begin
            term = 1'b1;
            return;
        end
        push(12'h000, rnd());
        case (op)
            4'h1, 4'h5, 4'h9: push(B_RFWE | B_CCLD, rnd());
            4'hE: push(B_RFWE, rnd());
            4'h0: push(((iv[11:9] & nv) != 3'b000) ? B_PCLD : 12'h000, rnd());
            4'hC: push(B_PCLD, rnd());
            4'h4: push(B_RFWE | B_PCLD, rnd());
            4'hF: begin
                push(12'h000, rnd());
                repeat (3) push(B_HALT, rnd());
                term = 1'b1;
            end
            4'h8, 4'hD: begin
                push(12'h000, rnd());
                repeat (3) push(B_FAULT, rnd());
                term = 1'b1;
            end
            default: begin
                push(12'h000, rnd());
                sel = (op == 4'h6 || op == 4'h7) ? 2'd2 : 2'd1;
                we  = (op == 4'h3 || op == 4'h7);
                ind = (op == 4'hA || op == 4'hB);
                ld  = (op == 4'h2 || op == 4'h6 || op == 4'hA);
                mem_phase(sel, we, d1, ind ? B_MDR : (ld ? (B_RFWE | B_CCLD) : 12'h000), to);
                if (to) begin
                    term = 1'b1;
                end else if (ind) begin
                    mem_phase(2'd3, op == 4'hB, d2, (op == 4'hA) ? (B_RFWE | B_CCLD) : 12'h000, to);
                    term = to;
                end
            end
        endcase
    endtask

    task automatic step(input bit a, output logic [11:0] o);
        mem_ack = a;
        #1 o = obs_w;
        @(negedge clk);
    endtask

    task automatic drive_trace();
        logic [11:0] o;
        obs_q.delete();
        foreach (ack_q[i]) begin
            step(ack_q[i], o);
            obs_q.push_back(o);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (obs_w !== req_vec(1'b0, 2'd0)) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", obs_w, req_vec(1'b0, 2'd0));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (obs_w !== req_vec(1'b0, 2'd0)) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs_w, req_vec(1'b0, 2'd0));
        end
        @(negedge clk);
    endtask

    task automatic test_add();
        bit          term;
        logic [11:0] o;
        do_reset();
        ir  = 16'h1042;
        nzp = 3'b000;
        model_instr(ir, nzp, 2, 0, 0, term);
        drive_trace();
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL add_trace cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q[2] !== (req_vec(1'b0, 2'd0) | B_IRLD | B_PCINC)) begin
            failures++;
            $display("FAIL add_fetch_ack got=%h exp=%h", obs_q[2], req_vec(1'b0, 2'd0) | B_IRLD | B_PCINC);
        end
        checks++;
        if (obs_q[4] !== (B_RFWE | B_CCLD)) begin
            failures++;
            $display("FAIL add_exec got=%h exp=%h", obs_q[4], B_RFWE | B_CCLD);
        end
        step(1'b0, o);
        checks++;
        if (o !== req_vec(1'b0, 2'd0)) begin
            failures++;
            $display("FAIL add_refetch got=%h exp=%h", o, req_vec(1'b0, 2'd0));
        end
    endtask

    task automatic test_br();
        bit term;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            ir  = 16'h0405;
            nzp = (k == 0) ? 3'b010 : 3'b100;
            model_instr(ir, nzp, 0, 0, 0, term);
            drive_trace();
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL br_trace k=%0d cyc=%0d got=%h exp=%h", k, i, obs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (obs_q[2][5] !== ((k == 0) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL br_pc_ld k=%0d got=%b exp=%b", k, obs_q[2][5], (k == 0));
            end
        end
    endtask

    task automatic test_ldi();
        bit term;
        do_reset();
        ir  = 16'hA1FF;
        nzp = 3'b001;
        model_instr(ir, nzp, 0, 0, 0, term);
        drive_trace();
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL ldi_trace cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({obs_q[0][9:8], obs_q[3][9:8], obs_q[4][9:8]} !== 6'b00_01_11) begin
            failures++;
            $display("FAIL ldi_sel_seq got=%0d,%0d,%0d exp=0,1,3", obs_q[0][9:8], obs_q[3][9:8], obs_q[4][9:8]);
        end
        checks++;
        if ({obs_q[3][2], obs_q[4][4:3]} !== 3'b111) begin
            failures++;
            $display("FAIL ldi_loads got=%b exp=111", {obs_q[3][2], obs_q[4][4:3]});
        end
    endtask

    task automatic test_str();
        bit term;
        do_reset();
        ir  = 16'h7240;
        nzp = 3'b000;
        model_instr(ir, nzp, 0, 4, 0, term);
        drive_trace();
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL str_trace cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        for (int i = 3; i < 8; i++) begin
            checks++;
            if ({obs_q[i][11:8], obs_q[i][4]} !== 5'b1110_0) begin
                failures++;
                $display("FAIL str_mem_stable cyc=%0d got=%b exp=11100", i, {obs_q[i][11:8], obs_q[i][4]});
            end
        end
    endtask

    task automatic test_timeout();
        bit term;
        do_reset();
        ir  = 16'h1042;
        nzp = 3'b000;
        model_instr(ir, nzp, T - 1, 0, 0, term);
        drive_trace();
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL tmo_ack_last cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({obs_q[T-1][7], obs_q[T+1][0]} !== 2'b10) begin
            failures++;
            $display("FAIL tmo_ack_wins got=%b exp=10", {obs_q[T-1][7], obs_q[T+1][0]});
        end
        do_reset();
        model_instr(ir, nzp, T, 0, 0, term);
        drive_trace();
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL tmo_fault cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({obs_q[T-1][0], obs_q[T][0]} !== 2'b01) begin
            failures++;
            $display("FAIL tmo_fault_edge got=%b exp=01", {obs_q[T-1][0], obs_q[T][0]});
        end
    endtask

    task automatic test_halt_reset();
        bit          term;
        logic [11:0] o;
        do_reset();
        ir  = 16'hF025;
        nzp = 3'b000;
        model_instr(ir, nzp, 1, 0, 0, term);
        drive_trace();
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL halt_trace cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        o = obs_q[obs_q.size() - 1];
        checks++;
        if ({o[11], o[1]} !== 2'b01) begin
            failures++;
            $display("FAIL halt_sticky got=%b exp=01", {o[11], o[1]});
        end
        do_reset();
        #1;
        checks++;
        if (obs_w !== req_vec(1'b0, 2'd0)) begin
            failures++;
            $display("FAIL halt_exit got=%h exp=%h", obs_w, req_vec(1'b0, 2'd0));
        end
        ir = 16'h2000;
        step(1'b1, o);
        step(rnd(), o);
        step(rnd(), o);
        step(1'b0, o);
        checks++;
        if (o !== req_vec(1'b0, 2'd1)) begin
            failures++;
            $display("FAIL ld_mem_wait got=%h exp=%h", o, req_vec(1'b0, 2'd1));
        end
        step(1'b0, o);
        rst     = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (obs_w !== req_vec(1'b0, 2'd0)) begin
            failures++;
            $display("FAIL rst_mid_mem got=%h exp=%h", obs_w, req_vec(1'b0, 2'd0));
        end
        model_instr(ir, nzp, T - 1, 1, 0, term);
        drive_trace();
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL post_rst_trace cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit term;
        int d[3];
        do_reset();
        for (int n = 0; n < 80; n++) begin
            ir  = 16'($urandom);
            nzp = 3'($urandom);
            for (int j = 0; j < 3; j++)
                d[j] = ($urandom_range(0, 11) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 3);
            model_instr(ir, nzp, d[0], d[1], d[2], term);
            drive_trace();
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_trace n=%0d cyc=%0d ir=%h got=%h exp=%h", n, i, ir, obs_q[i], exp_q[i]);
                end
            end
            if (term) do_reset();
        end
    endtask

    initial begin
        rst     = 1'b1;
        ir      = 16'h0000;
        nzp     = 3'b000;
        mem_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_br();
        test_ldi();
        test_str();
        test_timeout();
        test_halt_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
